// File: rtl/kmi_pkg.sv
// Shared definitions for the APB KMI receiver: register offsets, STATUS/CTRL bit
// positions, the receive-state encoding and the frame parity helper.
package kmi_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h01;
    localparam logic [7:0] ADDR_DATA   = 8'h02;

    localparam int CTRL_RX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int ST_NOT_EMPTY  = 0;
    localparam int ST_FULL       = 1;
    localparam int ST_PARITY_ERR = 2;
    localparam int ST_FRAME_ERR  = 3;
    localparam int ST_OVERRUN    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // Frames carry odd parity across the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/kmi_rx_fifo.sv
// Byte-wide receive FIFO. A push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle; popping an empty FIFO does nothing.
module kmi_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_VAL = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_VAL);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/apb_kmi_peripheral.sv
// APB slave PS/2-style receiver: line synchroniser, frame FSM, RX FIFO, CTRL/STATUS/DATA
// registers and a level interrupt. Define KMI_TIMEOUT_EN to add the mid-frame idle timeout.
module apb_kmi_peripheral
    import kmi_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int WAIT_STATES    = 1,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [7:0]  paddr,
    input  logic [15:0] pw_data,
    output logic [15:0] pr_data,
    output logic        pready,
    input  logic        kmi_clk_in,
    input  logic        kmi_data_in,
    output logic        kmiintr
);

    localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [WW-1:0] WS_VAL = WW'(WAIT_STATES);

    // Valid/ready: a transfer completes on the clock edge where psel, penable and pready
    // are all high; register side effects happen only on that edge, never on an aborted access.
    logic          access, pready_c, wr_xfer, rd_xfer;
    logic [WW-1:0] wait_cnt_q;
    logic          done_q;

    assign access   = psel & penable;
    assign pready_c = access & ~done_q & (wait_cnt_q == WS_VAL);
    assign pready   = pready_c & ~reset;
    assign wr_xfer  = pready & pwrite;
    assign rd_xfer  = pready & ~pwrite;

    always_ff @(posedge clk) begin
        if (reset || !access) begin
            wait_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            if (pready_c) done_q <= 1'b1;
            if (wait_cnt_q != WS_VAL) wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    // Device lines idle high; reset the synchronisers high so reset cannot fake an edge.
    logic [1:0] clk_sync_q, data_sync_q;
    logic       clk_prev_q, kmi_data_s, strobe;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], kmi_clk_in};
            data_sync_q <= {data_sync_q[0], kmi_data_in};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign kmi_data_s = data_sync_q[1];
    assign strobe     = clk_prev_q & ~clk_sync_q[1];

    logic [1:0] ctrl_q;
    logic       perr_q, ferr_q, ovr_q, irq_q;
    logic       rx_en;

    assign rx_en = ctrl_q[CTRL_RX_EN];

    rx_state_t  state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       rx_push, set_perr, set_ferr;

`ifdef KMI_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            to_expire;

    assign to_expire = (state_q != IDLE) && !strobe && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset || !rx_en || state_q == IDLE || strobe) to_cnt_q <= '0;
        else                                               to_cnt_q <= to_cnt_q + 1'b1;
    end
`else
    logic timeout_unused;
    assign timeout_unused = |TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        rx_push   = 1'b0;
        set_perr  = 1'b0;
        set_ferr  = 1'b0;
        if (!rx_en) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end else if (strobe) begin
            case (state_q)
                IDLE: begin
                    if (!kmi_data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {kmi_data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = kmi_data_s;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!kmi_data_s)                        set_ferr = 1'b1;
                    else if (odd_parity_ok(shift_q, par_q)) rx_push  = 1'b1;
                    else                                    set_perr = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef KMI_TIMEOUT_EN
        else if (to_expire) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            set_ferr  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
        end
    end

    logic [7:0] fifo_head;
    logic       fifo_full, fifo_empty, pop_req, pop_ok;

    assign pop_req = rd_xfer & (paddr == ADDR_DATA);
    assign pop_ok  = pop_req & ~fifo_empty;

    kmi_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (rx_push),
        .data_i  (shift_q),
        .pop_i   (pop_req),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    logic w1c, set_ovr, pw_data_unused;
    assign w1c            = wr_xfer & (paddr == ADDR_STATUS);
    assign set_ovr        = rx_push & fifo_full & ~pop_ok;
    assign pw_data_unused = ^pw_data[15:5];

    // Sticky error flags: a new fault in the same cycle as its clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= 2'b00;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_xfer && paddr == ADDR_CTRL) ctrl_q <= pw_data[1:0];
            perr_q <= (perr_q & ~(w1c & pw_data[ST_PARITY_ERR])) | set_perr;
            ferr_q <= (ferr_q & ~(w1c & pw_data[ST_FRAME_ERR]))  | set_ferr;
            ovr_q  <= (ovr_q  & ~(w1c & pw_data[ST_OVERRUN]))    | set_ovr;
            irq_q  <= ctrl_q[CTRL_IRQ_EN] & (~fifo_empty | perr_q | ferr_q | ovr_q);
        end
    end

    assign kmiintr = irq_q;

    logic [15:0] rdata;
    always_comb begin
        rdata = 16'h0000;
        case (paddr)
            ADDR_CTRL:   rdata = {14'h0000, ctrl_q};
            ADDR_STATUS: rdata = {11'h000, ovr_q, ferr_q, perr_q, fifo_full, ~fifo_empty};
            ADDR_DATA:   rdata = {8'h00, fifo_head};
            default:     rdata = 16'h0000;
        endcase
    end

    assign pr_data = rd_xfer ? rdata : 16'h0000;

endmodule

// File: tb/tb_apb_kmi_peripheral.sv
// Scoreboard bench for apb_kmi_peripheral: directed scenarios plus randomized frames and
// register traffic, checked against a queue-based model of the register/FIFO behaviour.
module tb_apb_kmi_peripheral;

  localparam int DEPTH = 8;
  localparam int WS    = 3;
  localparam int TO    = 100;
  localparam int KH    = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = 8'h00;
  logic [15:0] pw_data = 16'h0000;
  logic [15:0] pr_data;
  logic        pready;
  logic        kmi_clk_in = 1'b1, kmi_data_in = 1'b1;
  logic        kmiintr;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];

  logic [7:0] mq[$];
  logic       m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
  logic [1:0] m_ctrl = 2'b00;

  apb_kmi_peripheral #(
    .FIFO_DEPTH     (DEPTH),
    .WAIT_STATES    (WS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pw_data     (pw_data),
    .pr_data     (pr_data),
    .pready      (pready),
    .kmi_clk_in  (kmi_clk_in),
    .kmi_data_in (kmi_data_in),
    .kmiintr     (kmiintr)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no completion, required completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [15:0] m_status();
    return {11'h000, m_ovr, m_ferr, m_perr, mq.size() == DEPTH, mq.size() != 0};
  endfunction

  function automatic logic m_irq();
    return m_ctrl[1] & ((mq.size() != 0) | m_perr | m_ferr | m_ovr);
  endfunction

  task automatic m_read(input logic [7:0] addr, output logic [15:0] e);
    e = 16'h0000;
    if (addr == 8'h00) e = {14'h0000, m_ctrl};
    else if (addr == 8'h01) e = m_status();
    else if (addr == 8'h02 && mq.size() != 0) e = {8'h00, mq.pop_front()};
  endtask

  task automatic m_write(input logic [7:0] addr, input logic [15:0] d);
    if (addr == 8'h00) m_ctrl = d[1:0];
    else if (addr == 8'h01) begin
      if (d[2]) m_perr = 1'b0;
      if (d[3]) m_ferr = 1'b0;
      if (d[4]) m_ovr  = 1'b0;
    end
  endtask

  task automatic m_frame(input logic [7:0] b, input logic par_ok, input logic stop_ok);
    if (!m_ctrl[0]) return;
    if (!stop_ok) m_ferr = 1'b1;
    else if (!par_ok) m_perr = 1'b1;
    else if (mq.size() == DEPTH) m_ovr = 1'b1;
    else mq.push_back(b);
  endtask

  task automatic m_reset();
    mq.delete();
    m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_ctrl = 2'b00;
  endtask

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic kmi_bit(input logic b);
    kmi_data_in = b;
    wait_cyc(KH);
    kmi_clk_in = 1'b0;
    wait_cyc(KH);
    kmi_clk_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    kmi_bit(1'b0);
    for (int i = 0; i < 8; i++) kmi_bit(b[i]);
    kmi_bit(~(^b) ^ bad_par);
    kmi_bit(~bad_stop);
    kmi_data_in = 1'b1;
    wait_cyc(KH + 4);
    m_frame(b, !bad_par, !bad_stop);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    kmi_bit(1'b0);
    for (int i = 0; i < nbits; i++) kmi_bit(b[i]);
    kmi_data_in = 1'b1;
    wait_cyc(KH);
  endtask

  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [15:0] wdata,
                          input logic hold);
    int  n;
    logic got;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pw_data = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (pready) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!got || n != WS + 1) begin
      failures++;
      $display("FAIL pready_latency addr=%0h: got pready on access cycle %0d (seen=%0b), required cycle %0d",
               addr, n, got, WS + 1);
    end
    @(posedge clk); #1;
    if (hold) begin
      @(negedge clk);
      checks++;
      if (pready !== 1'b0) begin
        failures++;
        $display("FAIL pready_width: got pready=%0b in cycle after completion, required 0", pready);
      end
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] addr, input logic hold = 1'b0);
    logic [15:0] e;
    m_read(addr, e);
    exp_q.push_back(e);
    apb_xfer(1'b0, addr, 16'h0000, hold);
  endtask

  task automatic apb_write(input logic [7:0] addr, input logic [15:0] d);
    m_write(addr, d);
    apb_xfer(1'b1, addr, d, 1'b0);
  endtask

  task automatic apb_abort(input logic [7:0] addr);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic check_irq(input string name);
    wait_cyc(2);
    @(negedge clk);
    checks++;
    if (kmiintr !== m_irq()) begin
      failures++;
      $display("FAIL irq_%s: got kmiintr=%0b, required %0b", name, kmiintr, m_irq());
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    m_reset();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (pready && psel && penable && !pwrite) begin
      logic [15:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read addr=%0h: got pr_data=%04h, required no read", paddr, pr_data);
      end else begin
        e = exp_q.pop_front();
        if (pr_data !== e) begin
          failures++;
          $display("FAIL read addr=%0h: got pr_data=%04h, required %04h", paddr, pr_data, e);
        end
      end
    end
  end

  // stimulus
  initial begin
    int op;
    logic [7:0] b;
    wait_cyc(2);
    @(negedge clk);
    checks++;
    if (pr_data !== 16'h0000 || pready !== 1'b0 || kmiintr !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got pr_data=%04h pready=%0b kmiintr=%0b, required 0000 0 0",
               pr_data, pready, kmiintr);
    end
    wait_cyc(1);
    reset = 1'b0;
    apb_read(8'h01);
    apb_read(8'h00);

    apb_write(8'h00, 16'h0003);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_irq("after_rx");
    apb_read(8'h01);
    apb_read(8'h02);
    apb_read(8'h01);
    check_irq("after_pop");

    send_frame(8'h1C, 1'b1, 1'b0);
    apb_read(8'h01);
    check_irq("parity");
    apb_write(8'h01, 16'h0004);
    apb_read(8'h01);

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
    apb_read(8'h01);
    for (int i = 0; i < 8; i++) apb_read(8'h02);
    apb_read(8'h02);
    apb_write(8'h01, 16'h0010);
    apb_read(8'h01);

    send_frame(8'hE7, 1'b0, 1'b1);
    apb_read(8'h01);
    apb_write(8'h01, 16'h001C);

    send_frame(8'hA5, 1'b0, 1'b0);
    apb_abort(8'h02);
    apb_read(8'h00, 1'b1);
    apb_read(8'h02);
    apb_read(8'h05);

    apb_write(8'h00, 16'h0002);
    send_frame(8'h77, 1'b0, 1'b0);
    apb_read(8'h01);
    apb_write(8'h00, 16'h0003);
    send_partial(8'hFF, 4);
    apb_write(8'h00, 16'h0000);
    apb_write(8'h00, 16'h0003);
    send_frame(8'h3C, 1'b0, 1'b0);
    apb_read(8'h02);

    send_partial(8'h0F, 4);
    pulse_reset();
    check_irq("reset");
    apb_read(8'h00);
    apb_write(8'h00, 16'h0003);
    send_frame(8'h55, 1'b0, 1'b0);
    apb_read(8'h01);
    apb_read(8'h02);

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        b = 8'($urandom_range(0, 255));
        send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      end else if (op <= 7) begin
        apb_read(($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 2)));
      end else if (op == 8) begin
        apb_write(8'h01, 16'($urandom_range(0, 31)) << 0);
      end else begin
        apb_write(8'h00, {14'h0000, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0});
      end
      check_irq("random");
    end
    apb_read(8'h01);

`ifdef KMI_TIMEOUT_EN
    while (mq.size() != 0) apb_read(8'h02);
    apb_write(8'h01, 16'h001C);
    apb_write(8'h00, 16'h0003);
    send_partial(8'h06, 3);
    wait_cyc(TO + 20);
    m_ferr = 1'b1;
    apb_read(8'h01);
    send_frame(8'h42, 1'b0, 1'b0);
    apb_read(8'h02);
`endif

    wait_cyc(5);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_reads: got %0d unanswered reads, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
